// File: rtl/wishbone_master_bridge.sv
// rtl/wishbone_master_bridge.sv - single-transfer classic Wishbone initiator bridging a command/response stream
//
// Purpose: takes one command from the req_* valid/ready stream, runs exactly one
// classic Wishbone cycle for it, and returns read data / error status on the rsp_*
// valid/ready stream. Only one transfer is ever outstanding.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a bus cycle that sees no
// ack/err within TIMEOUT_CYCLES bus cycles. Without it the bus waits indefinitely
// and rsp_timeout is constant 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           command handshake
//   req_we/req_adr/req_sel/req_dat command fields, latched on accept
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat/rsp_err/rsp_timeout   response fields, held until consumed
//   wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_dat_mosi   bus outputs (all registered)
//   wb_dat_miso/wb_ack/wb_err     bus inputs from the slaves
module wishbone_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_mosi,
    input  logic [31:0] wb_dat_miso,
    input  logic        wb_ack,
    input  logic        wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort on the bus cycle whose increment would bring the count to TIMEOUT_CYCLES,
    // so the cycle is dropped after exactly TIMEOUT_CYCLES silent bus cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
`else
    // Timeout logic is compiled out; the comparison is always false and keeps the
    // parameter referenced in this build.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= '0;
            wb_sel      <= '0;
            wb_dat_mosi <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone is the accept.
                    if (req_valid) begin
                        wb_cyc      <= 1'b1;
                        wb_stb      <= 1'b1;
                        wb_we       <= req_we;
                        wb_adr      <= req_adr;
                        wb_sel      <= req_sel;
                        wb_dat_mosi <= req_dat;
                        req_ready   <= 1'b0;
                        state       <= BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end

                BUS: begin
                    // Drop cyc on the very edge that sees ack/err so a slave that only
                    // acks while ack is low cannot produce a second ack.
                    if (wb_ack || wb_err) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= wb_err;
                        rsp_dat   <= (wb_err || wb_we) ? 32'h0 : wb_dat_miso;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_dat     <= '0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    // Late or stray ack/err are ignored here; only the consumer matters.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    wb_cyc    <= 1'b0;
                    wb_stb    <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master_bridge.sv
// tb/tb_wishbone_master_bridge.sv - randomized self-checking bench for wishbone_master_bridge
module tb_wishbone_master_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_dat;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [31:0] wb_adr, wb_dat_mosi, wb_dat_miso;
    logic [3:0]  wb_sel;

    always #5 clk = ~clk;

    wishbone_master_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_mosi(wb_dat_mosi), .wb_dat_miso(wb_dat_miso),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1;
    endfunction

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // controls written only by the main process
    bit slave_mute = 0, slave_rand = 0, spur_en = 0, rdy_rand = 0, rdy_force = 1;
    int spur_req = 0;

    // monitor-owned state
    bit          busy = 0, rsp_seen = 0;
    logic        cur_we;
    logic [31:0] cur_adr, cur_dat;
    logic [3:0]  cur_sel;
    int          n_acc = 0, n_rsp = 0, t_acc = 0, t_rsp = 0, ncyc = 0;
    logic [31:0] last_dat, last_bus_adr, last_bus_dat;
    logic        last_err, last_tmo, last_bus_we;
    logic [3:0]  last_bus_sel;
    int          acks_given = 0;

    // ---------------- slave ----------------
    initial begin
        int cnt = 0;
        int d = 0;
        int spur_seen = 0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_miso = '0;
        forever begin
            @(posedge clk); #1;
            if (wb_ack || wb_err) begin
                wb_ack = 1'b0; wb_err = 1'b0; wb_dat_miso = $urandom; cnt = 0;
            end else if (wb_cyc && wb_stb) begin
                if (!slave_mute) begin
                    if (cnt == 0) d = slave_rand ? int'($urandom_range(0, 3)) : 0;
                    cnt++;
                    if (cnt >= d + 2) begin
                        acks_given++;
                        if (unmapped(wb_adr)) begin
                            wb_err = 1'b1;
                            wb_ack = 1'($urandom_range(0, 1));
                            wb_dat_miso = $urandom;
                        end else begin
                            wb_ack = 1'b1;
                            if (wb_we) begin
                                slave_mem[wb_adr] = merge(slave_mem.exists(wb_adr) ? slave_mem[wb_adr] : init_val(wb_adr),
                                                          wb_dat_mosi, wb_sel);
                                wb_dat_miso = $urandom;
                            end else begin
                                wb_dat_miso = slave_mem.exists(wb_adr) ? slave_mem[wb_adr] : init_val(wb_adr);
                            end
                        end
                    end
                end
            end else begin
                cnt = 0;
                if (spur_req != spur_seen || (spur_en && $urandom_range(0, 9) == 0)) begin
                    spur_seen = spur_req;
                    wb_ack = 1'b1;
                    wb_err = 1'($urandom_range(0, 1));
                    wb_dat_miso = $urandom;
                end
            end
        end
    end

    // ---------------- response consumer ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        bit   rst_prev = 1;
        bit   gen_ack_prev = 0;
        rsp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                exp_q.delete();
                busy = 0;
                n_acc = n_rsp;
                rst_prev = 1;
                gen_ack_prev = 0;
                continue;
            end
            if (rst_prev) begin
                rst_prev = 0;
                chk("rst_cyc", wb_cyc, 0);
                chk("rst_stb", wb_stb, 0);
                chk("rst_we", wb_we, 0);
                chk("rst_adr", wb_adr, 0);
                chk("rst_sel", wb_sel, 0);
                chk("rst_dat_mosi", wb_dat_mosi, 0);
                chk("rst_req_ready", req_ready, 1);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_dat", rsp_dat, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_timeout", rsp_timeout, 0);
            end
            chk("req_ready_idle", req_ready, !busy);
            chk("stb_eq_cyc", wb_stb, wb_cyc);
            if (gen_ack_prev) chk("cyc_after_ack", wb_cyc, 0);
            if (wb_cyc) begin
                chk("cyc_outstanding", busy, 1);
                chk("bus_adr", wb_adr, cur_adr);
                chk("bus_sel", wb_sel, cur_sel);
                chk("bus_we", wb_we, cur_we);
                chk("bus_dat", wb_dat_mosi, cur_dat);
                last_bus_adr = wb_adr; last_bus_sel = wb_sel;
                last_bus_we = wb_we;   last_bus_dat = wb_dat_mosi;
            end
            if (rsp_valid) begin
                chk("rsp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("rsp_dat", rsp_dat, exp_q[0].dat);
                    chk("rsp_err", rsp_err, exp_q[0].err);
                    chk("rsp_timeout", rsp_timeout, exp_q[0].tmo);
                    if (!rsp_seen) begin t_rsp = ncyc; rsp_seen = 1; end
                    last_dat = rsp_dat; last_err = rsp_err; last_tmo = rsp_timeout;
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        busy = 0;
                        n_rsp++;
                    end
                end
            end
            gen_ack_prev = (wb_ack || wb_err) && wb_cyc;
            if (req_valid && req_ready) begin
                cur_we = req_we; cur_adr = req_adr; cur_sel = req_sel; cur_dat = req_dat;
                busy = 1; rsp_seen = 0; t_acc = ncyc; n_acc++;
                if (slave_mute)              e = '{32'h0, 1'b1, 1'b1};
                else if (unmapped(req_adr))  e = '{32'h0, 1'b1, 1'b0};
                else if (req_we) begin
                    model_mem[req_adr] = merge(model_mem.exists(req_adr) ? model_mem[req_adr] : init_val(req_adr),
                                               req_dat, req_sel);
                    e = '{32'h0, 1'b0, 1'b0};
                end else
                    e = '{model_mem.exists(req_adr) ? model_mem[req_adr] : init_val(req_adr), 1'b0, 1'b0};
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bit ok = 0;
        int i = 0;
        @(posedge clk); #1;
        req_we = we; req_adr = adr; req_sel = sel; req_dat = dat; req_valid = 1'b1;
        while (!ok && i < 300) begin
            @(negedge clk);
            ok = req_ready && !rst;
            @(posedge clk); #1;
            i++;
        end
        chk("send_accept", ok, 1);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_adr = $urandom; req_sel = 4'($urandom); req_dat = $urandom;
    endtask

    task automatic wait_rsp(input int target, input string name);
        int i = 0;
        while (n_rsp < target && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        chk({name, "_done"}, n_rsp >= target, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int target;
        int i;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: read with a zero-wait registered-ack slave
        model_mem[32'h1000_0000] = 32'h0000_A5A5;
        slave_mem[32'h1000_0000] = 32'h0000_A5A5;
        target = n_rsp + 1;
        send(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        wait_rsp(target, "t1");
        chk("t1_edges_to_rsp", t_rsp - t_acc - 1, 2);
        chk("t1_dat", last_dat, 32'h0000_A5A5);
        chk("t1_err", last_err, 0);

        // 2: partial write, then read back the merged word
        model_mem[32'h1000_0004] = 32'h1234_5678;
        slave_mem[32'h1000_0004] = 32'h1234_5678;
        i = acks_given;
        target = n_rsp + 1;
        send(1'b1, 32'h1000_0004, 4'b0011, 32'hDEAD_BEEF);
        wait_rsp(target, "t2");
        chk("t2_bus_adr", last_bus_adr, 32'h1000_0004);
        chk("t2_bus_sel", last_bus_sel, 4'b0011);
        chk("t2_bus_dat", last_bus_dat, 32'hDEAD_BEEF);
        chk("t2_bus_we", last_bus_we, 1);
        chk("t2_ack_count", acks_given - i, 1);
        chk("t2_rsp_dat", last_dat, 0);
        chk("t2_rsp_err", last_err, 0);
        send(1'b0, 32'h1000_0004, 4'hF, 32'h0);
        wait_rsp(target + 1, "t2_rb");
        chk("t2_readback", last_dat, 32'h1234_BEEF);

        // 3: unmapped address answered with err
        target = n_rsp + 1;
        send(1'b0, 32'hFFFF_FFF0, 4'hF, 32'h0);
        wait_rsp(target, "t3");
        chk("t3_err", last_err, 1);
        chk("t3_dat", last_dat, 0);
        chk("t3_timeout", last_tmo, 0);

        // 4: response backpressure with a second read queued behind it
        @(negedge clk);
        rdy_force = 1'b0;
        target = n_rsp + 1;
        send(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        fork
            send(1'b0, 32'h1000_0004, 4'hF, 32'h0);
        join_none
        i = 0;
        while (!rsp_valid && i < 50) begin @(negedge clk); i++; end
        chk("t4_valid", rsp_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_dat", rsp_dat, 32'h0000_A5A5);
            chk("t4_hold_cyc", wb_cyc, 0);
            chk("t4_hold_req_ready", req_ready, 0);
        end
        rdy_force = 1'b1;
        wait_rsp(target, "t4_a");
        @(negedge clk);
        chk("t4_req_ready_next", req_ready, 1);
        @(negedge clk);
        chk("t4_second_cyc", wb_cyc, 1);
        chk("t4_second_adr", wb_adr, 32'h1000_0004);
        wait_rsp(target + 1, "t4_b");
        chk("t4_second_dat", last_dat, 32'h1234_BEEF);

        // 5: silent slave
        slave_mute = 1;
`ifdef WB_MASTER_TIMEOUT_EN
        @(negedge clk);
        rdy_force = 1'b0;
        target = n_rsp + 1;
        send(1'b0, 32'h1000_0010, 4'hF, 32'h0);
        i = 0;
        while (!rsp_valid && i < 50) begin @(negedge clk); i++; end
        @(posedge clk); #1;
        chk("t5_valid", rsp_valid, 1);
        chk("t5_edges_to_rsp", t_rsp - t_acc - 1, TMO);
        chk("t5_err", last_err, 1);
        chk("t5_timeout", last_tmo, 1);
        chk("t5_dat", last_dat, 0);
        @(posedge clk); #1;
        spur_req++;
        repeat (3) begin
            @(negedge clk);
            chk("t5_late_ack_valid", rsp_valid, 1);
            chk("t5_late_ack_timeout", rsp_timeout, 1);
        end
        rdy_force = 1'b1;
        wait_rsp(target, "t5");
        send(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
`else
        send(1'b0, 32'h1000_0010, 4'hF, 32'h0);
        repeat (40) @(negedge clk);
        chk("t5_hold_cyc", wb_cyc, 1);
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_timeout_zero", rsp_timeout, 0);
        @(posedge clk); #1;
`endif

        // 6: reset in the middle of a bus cycle
        @(negedge clk);
        chk("t6_cyc_before", wb_cyc, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        slave_mute = 0;
        @(negedge clk);
        chk("t6_cyc", wb_cyc, 0);
        chk("t6_stb", wb_stb, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_req_ready", req_ready, 1);
        repeat (10) @(negedge clk);
        chk("t6_no_rsp", rsp_valid, 0);
        @(posedge clk); #1;

        // randomized traffic: wait states, err slaves, stray acks, random backpressure
        slave_rand = 1; spur_en = 1; rdy_rand = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 6) == 0) a = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
            else                           a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
        end
        i = 0;
        while (n_rsp < n_acc && i < 500) begin @(posedge clk); #1; i++; end
        chk("drain_outstanding", n_acc - n_rsp, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
